// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, reads the instruction memory combinationally and
// queues {pc, instr} pairs for decode; redirects flush the queue and reload the PC.
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned QDEPTH   = 2,
  parameter logic [31:0] NOP      = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] Inst_Address,
  input  logic [31:0] Instruction,
  input  logic        redirect,
  input  logic [63:0] redirect_target,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instruction,
  output logic [63:0] id_pc,
  output logic [31:0] fetch_count
);

  localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  fq_entry_t               fifo_q [QDEPTH];
  fq_entry_t               fifo_d [QDEPTH];
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [63:0]             pc_q, pc_d;
  logic [31:0]             fetch_count_q, fetch_count_d;

  logic      pop;
  logic      fire;
  fq_entry_t head;

  assign head = fifo_q[rd_ptr_q];

  // Redirect masks the head in the same cycle so decode never consumes a
  // wrong-path instruction while the flush is in flight.
  assign id_valid       = (count_q != '0) && !redirect;
  assign id_instruction = id_valid ? head.instr : NOP;
  assign id_pc          = id_valid ? head.pc : 64'h0;
  assign Inst_Address   = pc_q;
  assign fetch_count    = fetch_count_q;

  assign pop  = id_valid && id_ready;
  // A pop frees a slot this cycle, so a full queue can still accept a push.
  assign fire = !redirect && ((count_q < FULL_CNT) || pop);

  always_comb begin
    fifo_d        = fifo_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    pc_d          = pc_q;
    fetch_count_d = fetch_count_q;

    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      pc_d     = redirect_target & ~64'h3;
    end else begin
      if (pop) begin
        rd_ptr_d      = rd_ptr_q + PTR_W'(1);
        fetch_count_d = fetch_count_q + 32'd1;
      end
      if (fire) begin
        fifo_d[wr_ptr_q] = '{pc: pc_q, instr: Instruction};
        wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        pc_d             = pc_q + 64'd4;
      end
      case ({fire, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      pc_q          <= RESET_PC;
      fetch_count_q <= '0;
      for (int i = 0; i < int'(QDEPTH); i++) fifo_q[i] <= '0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
      fifo_q        <= fifo_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus a randomized run
// against a queue-based reference model of the fetch stage.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_target = 64'h0;
  logic        id_ready = 1'b0;

  logic [63:0] Inst_Address, Inst_Address_w;
  logic [31:0] Instruction, Instruction_w;
  logic        id_valid, id_valid_w;
  logic [31:0] id_instruction, id_instruction_w;
  logic [63:0] id_pc, id_pc_w;
  logic [31:0] fetch_count, fetch_count_w;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'h0:   return 32'h10000293;
      64'h4:   return 32'h00700313;
      64'h8:   return 32'h00000413;
      64'h40:  return 32'h00d74463;
      64'h44:  return 32'h00000663;
      default: return (a[31:0] * 32'h9E3779B1) ^ a[63:32];
    endcase
  endfunction

  assign Instruction   = mem_word(Inst_Address);
  assign Instruction_w = mem_word(Inst_Address_w);

  instruction_fetch_unit #(.RESET_PC(64'h0), .QDEPTH(2), .NOP(NOP)) dut (
    .clk(clk), .reset(reset), .Inst_Address(Inst_Address), .Instruction(Instruction),
    .redirect(redirect), .redirect_target(redirect_target), .id_ready(id_ready),
    .id_valid(id_valid), .id_instruction(id_instruction), .id_pc(id_pc),
    .fetch_count(fetch_count));

  instruction_fetch_unit #(.RESET_PC(WRAP_PC), .QDEPTH(2), .NOP(NOP)) dut_wrap (
    .clk(clk), .reset(reset), .Inst_Address(Inst_Address_w), .Instruction(Instruction_w),
    .redirect(redirect), .redirect_target(redirect_target), .id_ready(id_ready),
    .id_valid(id_valid_w), .id_instruction(id_instruction_w), .id_pc(id_pc_w),
    .fetch_count(fetch_count_w));

  // Leaves the bench 1ns into the first cycle after reset release (cycle C0).
  task automatic do_reset(input logic rdy);
    @(negedge clk);
    reset = 1'b1; redirect = 1'b0; redirect_target = 64'h0; id_ready = rdy;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    checks++; if (Inst_Address !== 64'h0) begin failures++; $display("FAIL rst_addr got=%h exp=%h", Inst_Address, 64'h0); end
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", id_valid); end
    checks++; if (id_instruction !== NOP) begin failures++; $display("FAIL rst_instr got=%h exp=%h", id_instruction, NOP); end
    checks++; if (id_pc !== 64'h0) begin failures++; $display("FAIL rst_pc got=%h exp=0", id_pc); end
    checks++; if (fetch_count !== 32'h0) begin failures++; $display("FAIL rst_fcnt got=%0d exp=0", fetch_count); end
  endtask

  task automatic test_stream();
    logic [63:0] exp_pc [3];
    logic [31:0] exp_in [3];
    exp_pc = '{64'h0, 64'h4, 64'h8};
    exp_in = '{32'h10000293, 32'h00700313, 32'h00000413};
    do_reset(1'b1);
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL stream_c0_valid got=%b exp=0", id_valid); end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, id_valid); end
      checks++; if (id_pc !== exp_pc[i]) begin failures++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, id_pc, exp_pc[i]); end
      checks++; if (id_instruction !== exp_in[i]) begin failures++; $display("FAIL stream_instr[%0d] got=%h exp=%h", i, id_instruction, exp_in[i]); end
      checks++; if (fetch_count !== 32'(i)) begin failures++; $display("FAIL stream_fcnt[%0d] got=%0d exp=%0d", i, fetch_count, i); end
    end
    next_cycle();
    checks++; if (fetch_count !== 32'd3) begin failures++; $display("FAIL stream_fcnt_end got=%0d exp=3", fetch_count); end
  endtask

  task automatic test_backpressure();
    do_reset(1'b0);
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      if (c >= 2) begin
        checks++; if (Inst_Address !== 64'h8) begin failures++; $display("FAIL bp_addr_hold[c%0d] got=%h exp=8", c, Inst_Address); end
      end
      checks++; if (id_pc !== 64'h0 || id_instruction !== 32'h10000293 || id_valid !== 1'b1) begin
        failures++; $display("FAIL bp_head[c%0d] got=%b/%h/%h exp=1/0/10000293", c, id_valid, id_pc, id_instruction); end
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); id_ready = 1'b1; #1;
      checks++; if (id_valid !== 1'b1 || id_pc !== 64'(4 * k)) begin
        failures++; $display("FAIL bp_release[%0d] got=%b/%h exp=1/%h", k, id_valid, id_pc, 64'(4 * k)); end
    end
  endtask

  task automatic test_redirect_full();
    do_reset(1'b1);
    next_cycle();                     // C1: pop pc0
    @(negedge clk); id_ready = 1'b0; #1;  // C2
    @(negedge clk); id_ready = 1'b1; redirect = 1'b1; redirect_target = 64'h40; #1;  // C3: full
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL redir_n_valid got=%b exp=0", id_valid); end
    checks++; if (fetch_count !== 32'd1) begin failures++; $display("FAIL redir_n_fcnt got=%0d exp=1", fetch_count); end
    @(negedge clk); redirect = 1'b0; #1;
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL redir_n1_valid got=%b exp=0", id_valid); end
    checks++; if (Inst_Address !== 64'h40) begin failures++; $display("FAIL redir_n1_addr got=%h exp=40", Inst_Address); end
    checks++; if (fetch_count !== 32'd1) begin failures++; $display("FAIL redir_n1_fcnt got=%0d exp=1", fetch_count); end
    next_cycle();
    checks++; if (id_valid !== 1'b1 || id_pc !== 64'h40 || id_instruction !== 32'h00d74463) begin
      failures++; $display("FAIL redir_n2_head got=%b/%h/%h exp=1/40/00d74463", id_valid, id_pc, id_instruction); end
    next_cycle();
    checks++; if (id_valid !== 1'b1 || id_pc !== 64'h44 || id_instruction !== 32'h00000663) begin
      failures++; $display("FAIL redir_n3_head got=%b/%h/%h exp=1/44/00000663", id_valid, id_pc, id_instruction); end
    checks++; if (fetch_count !== 32'd2) begin failures++; $display("FAIL redir_n3_fcnt got=%0d exp=2", fetch_count); end
  endtask

  task automatic test_misaligned();
    @(negedge clk); id_ready = 1'b1; redirect = 1'b1; redirect_target = 64'h43; #1;
    @(negedge clk); redirect = 1'b0; #1;
    checks++; if (Inst_Address !== 64'h40) begin failures++; $display("FAIL misal_addr got=%h exp=40", Inst_Address); end
    next_cycle();
    checks++; if (id_valid !== 1'b1 || id_pc !== 64'h40) begin failures++; $display("FAIL misal_pc got=%b/%h exp=1/40", id_valid, id_pc); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); id_ready = 1'b1; redirect = 1'b1; redirect_target = 64'h100; #1;
    @(negedge clk); redirect_target = 64'h200; #1;
    checks++; if (Inst_Address !== 64'h100 || id_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_mid got=%h/%b exp=100/0", Inst_Address, id_valid); end
    @(negedge clk); redirect = 1'b0; #1;
    checks++; if (Inst_Address !== 64'h200 || id_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_addr got=%h/%b exp=200/0", Inst_Address, id_valid); end
    next_cycle();
    checks++; if (id_valid !== 1'b1 || id_pc !== 64'h200 || id_instruction !== mem_word(64'h200)) begin
      failures++; $display("FAIL b2b_head got=%b/%h/%h exp=1/200/%h", id_valid, id_pc, id_instruction, mem_word(64'h200)); end
  endtask

  task automatic test_reset_priority();
    do_reset(1'b1);
    next_cycle();
    @(negedge clk); id_ready = 1'b0; #1;
    next_cycle();                     // queue full, fetch_count nonzero
    @(negedge clk); reset = 1'b1; redirect = 1'b1; redirect_target = 64'h80; id_ready = 1'b1; #1;
    @(negedge clk); reset = 1'b0; redirect = 1'b0; id_ready = 1'b0; #1;
    checks++; if (Inst_Address !== 64'h0) begin failures++; $display("FAIL prio_addr got=%h exp=0", Inst_Address); end
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL prio_valid got=%b exp=0", id_valid); end
    checks++; if (id_instruction !== 32'h00000013) begin failures++; $display("FAIL prio_instr got=%h exp=00000013", id_instruction); end
    checks++; if (fetch_count !== 32'd0) begin failures++; $display("FAIL prio_fcnt got=%0d exp=0", fetch_count); end
  endtask

  task automatic test_wrap();
    do_reset(1'b1);
    checks++; if (Inst_Address_w !== WRAP_PC) begin failures++; $display("FAIL wrap_addr0 got=%h exp=%h", Inst_Address_w, WRAP_PC); end
    next_cycle();
    checks++; if (id_pc_w !== WRAP_PC || id_valid_w !== 1'b1) begin failures++; $display("FAIL wrap_pc0 got=%b/%h exp=1/%h", id_valid_w, id_pc_w, WRAP_PC); end
    next_cycle();
    checks++; if (id_pc_w !== 64'h0 || id_valid_w !== 1'b1) begin failures++; $display("FAIL wrap_pc1 got=%b/%h exp=1/0", id_valid_w, id_pc_w); end
  endtask

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } ent_t;

  // Reference: an in-order queue of fetched words, bounded at two entries.
  task automatic test_random();
    ent_t        mq[$];
    logic [63:0] mpc = 64'h0;
    logic [31:0] mfc = 32'h0;
    logic        ev, pop_m, room;
    logic [31:0] ei;
    logic [63:0] ep;
    do_reset(1'b1);
    for (int i = 0; i < 3000; i++) begin
      reset           = ($urandom_range(0, 199) == 0);
      redirect        = ($urandom_range(0, 11) == 0);
      redirect_target = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) redirect_target = 64'(4 * $urandom_range(0, 20)) + 64'($urandom_range(0, 3));
      id_ready        = ($urandom_range(0, 3) != 0);
      #1;
      ev = (mq.size() != 0) && !redirect;
      ei = ev ? mq[0].ins : NOP;
      ep = ev ? mq[0].pc : 64'h0;
      checks++; if (Inst_Address !== mpc) begin failures++; $display("FAIL rnd_addr[%0d] got=%h exp=%h", i, Inst_Address, mpc); end
      checks++; if (id_valid !== ev) begin failures++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, id_valid, ev); end
      checks++; if (id_instruction !== ei || id_pc !== ep) begin
        failures++; $display("FAIL rnd_head[%0d] got=%h/%h exp=%h/%h", i, id_pc, id_instruction, ep, ei); end
      checks++; if (fetch_count !== mfc) begin failures++; $display("FAIL rnd_fcnt[%0d] got=%0d exp=%0d", i, fetch_count, mfc); end
      if (reset) begin
        mq.delete(); mpc = 64'h0; mfc = 32'h0;
      end else if (redirect) begin
        mq.delete(); mpc = {redirect_target[63:2], 2'b00};
      end else begin
        pop_m = ev && id_ready;
        room  = (mq.size() < 2) || pop_m;
        if (pop_m) begin void'(mq.pop_front()); mfc = mfc + 32'd1; end
        if (room) begin mq.push_back('{mpc, mem_word(mpc)}); mpc = mpc + 64'd4; end
      end
      @(negedge clk);
    end
    reset = 1'b0; redirect = 1'b0; id_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_misaligned();
    test_back_to_back();
    test_reset_priority();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
